// File: rtl/matrix_address_generator.sv
// matrix_address_generator: sequences A/B/C addresses for C[MxP] = A[MxN] * B[NxP] into a core address register
//   clk, rst (async, active-high)                    clock and reset
//   start, dim_m/dim_n/dim_p, base_a/base_b/base_c   run request, dimensions and row-major bases (latched at start)
//   step                                             current access complete (honoured in WAIT states only)
//   ar_data, ar_write, sel                           address, one-cycle load strobe, operand tag (00 A, 01 B, 10 C)
//   last_k                                           B address closes the dot product
//   busy, done                                       run in progress, one-cycle finish pulse
module matrix_address_generator #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  dim_m,
  input  logic [DIM_WIDTH-1:0]  dim_n,
  input  logic [DIM_WIDTH-1:0]  dim_p,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_c,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] ar_data,
  output logic                  ar_write,
  output logic [1:0]            sel,
  output logic                  last_k,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, EMIT_A, WAIT_A, EMIT_B, WAIT_B, EMIT_C, WAIT_C, FIN} state_t;
  localparam logic [DIM_WIDTH-1:0]  one_d = DIM_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] one_a = ADDR_WIDTH'(1);
  state_t state, nxt;
  logic [DIM_WIDTH-1:0] m_r, n_r, p_r, i, j, k;
  logic [ADDR_WIDTH-1:0] b_r, row_a, col_b, ptr_b, ptr_c, addr_h, emit_addr;
  logic [1:0] sel_h, emit_sel;
  logic k_end, j_end, i_end, zero_dim;
  assign zero_dim = (dim_m == '0) || (dim_n == '0) || (dim_p == '0);
  assign k_end = k == n_r - one_d;
  assign j_end = j == p_r - one_d;
  assign i_end = i == m_r - one_d;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (zero_dim ? FIN : EMIT_A) : IDLE;
      EMIT_A:  nxt = WAIT_A;
      WAIT_A:  nxt = step ? EMIT_B : WAIT_A;
      EMIT_B:  nxt = WAIT_B;
      WAIT_B:  nxt = step ? (k_end ? EMIT_C : EMIT_A) : WAIT_B;
      EMIT_C:  nxt = WAIT_C;
      WAIT_C:  nxt = step ? ((i_end && j_end) ? FIN : EMIT_A) : WAIT_C;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign ar_write  = (state == EMIT_A) || (state == EMIT_B) || (state == EMIT_C);
  assign emit_addr = (state == EMIT_B) ? ptr_b : (state == EMIT_C) ? ptr_c : row_a + ADDR_WIDTH'(k);
  assign emit_sel  = (state == EMIT_B) ? 2'b01 : (state == EMIT_C) ? 2'b10 : 2'b00;
  // Outside EMIT cycles the last emitted address/tag is replayed from the hold registers.
  assign ar_data = ar_write ? emit_addr : addr_h;
  assign sel     = ar_write ? emit_sel : sel_h;
  assign last_k  = (state == EMIT_B) && k_end;
  assign busy    = state != IDLE;
  assign done    = state == FIN;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      m_r    <= '0;
      n_r    <= '0;
      p_r    <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      b_r    <= '0;
      row_a  <= '0;
      col_b  <= '0;
      ptr_b  <= '0;
      ptr_c  <= '0;
      addr_h <= '0;
      sel_h  <= '0;
    end else begin
      state <= nxt;
      if (ar_write) begin
        addr_h <= emit_addr;
        sel_h  <= emit_sel;
      end
      if (state == IDLE && start) begin
        m_r   <= dim_m;
        n_r   <= dim_n;
        p_r   <= dim_p;
        i     <= '0;
        j     <= '0;
        k     <= '0;
        b_r   <= base_b;
        row_a <= base_a;
        col_b <= base_b;
        ptr_b <= base_b;
        ptr_c <= base_c;
      end
      if (state == WAIT_B && step) begin
        if (k_end) k <= '0;
        else begin
          k     <= k + one_d;
          ptr_b <= ptr_b + ADDR_WIDTH'(p_r);
        end
      end
      // Each C closes one (i, j); ptr_b rewinds to the top of the next B column.
      if (state == WAIT_C && step) begin
        ptr_c <= ptr_c + one_a;
        if (j_end) begin
          j     <= '0;
          i     <= i + one_d;
          row_a <= row_a + ADDR_WIDTH'(n_r);
          col_b <= b_r;
          ptr_b <= b_r;
        end else begin
          j     <= j + one_d;
          col_b <= col_b + one_a;
          ptr_b <= col_b + one_a;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_address_generator.sv
// tb_matrix_address_generator: directed self-checking bench for matrix_address_generator
module tb_matrix_address_generator;
  logic clk = 0, rst = 1, start = 0, step = 0;
  logic [7:0] dim_m = 0, dim_n = 0, dim_p = 0;
  logic [15:0] base_a = 0, base_b = 0, base_c = 0, ar_data;
  logic ar_write, last_k, busy, done;
  logic [1:0] sel;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  matrix_address_generator dut (
    .clk(clk), .rst(rst), .start(start), .dim_m(dim_m), .dim_n(dim_n), .dim_p(dim_p),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .step(step),
    .ar_data(ar_data), .ar_write(ar_write), .sel(sel), .last_k(last_k), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] e(input logic [1:0] s, input logic l, input logic [15:0] a);
    return {13'b0, s, l, a};
  endfunction
  task automatic chk_idle(input string tag);
    chk(tag, {ar_data, ar_write, sel, last_k, busy, done}, '0);
  endtask
  task automatic stall(input string tag, input logic [15:0] held, input logic [1:0] hsel);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk(tag, {ar_write, done, busy, sel, ar_data}, {1'b0, 1'b0, 1'b1, hsel, held});
    end
  endtask
  // Runs with step held high, comparing every strobe against exp_q; optionally
  // pulses start and disturbs dim_n once pulse_at strobes have been seen.
  task automatic run(input string tag, input int pulse_at);
    int n = 0;
    bit fin = 0;
    step = 1;
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (ar_write) begin
        if (n < exp_q.size()) chk(tag, {13'b0, sel, last_k, ar_data}, exp_q[n]);
        else chk({tag, "_extra"}, n, exp_q.size() - 1);
        n++;
      end
      start = (n == pulse_at);
      if (n == pulse_at) dim_n = 8'd5;
      if (done) begin
        chk({tag, "_count"}, n, exp_q.size());
        fin = 1;
      end else tick();
    end
    chk({tag, "_finished"}, fin, 1);
    start = 0;
    step = 0;
    tick();
    chk({tag, "_after"}, {busy, done, ar_write}, 0);
  endtask
  initial begin
    // reset held while start/step toggle
    for (int c = 0; c < 4; c++) begin
      start = c[0];
      step = ~c[0];
      tick();
      chk_idle("reset_hold");
    end
    start = 0;
    step = 0;
    rst = 0;
    tick();
    chk_idle("reset_release");
    // 2x2x2 with first-strobe latency, mid-run start pulse and dim change
    dim_m = 2; dim_n = 2; dim_p = 2;
    base_a = 16'h0100; base_b = 16'h0200; base_c = 16'h0300;
    exp_q = '{e(0,0,16'h0100), e(1,0,16'h0200), e(0,0,16'h0101), e(1,1,16'h0202), e(2,0,16'h0300),
              e(0,0,16'h0100), e(1,0,16'h0201), e(0,0,16'h0101), e(1,1,16'h0203), e(2,0,16'h0301),
              e(0,0,16'h0102), e(1,0,16'h0200), e(0,0,16'h0103), e(1,1,16'h0202), e(2,0,16'h0302),
              e(0,0,16'h0102), e(1,0,16'h0201), e(0,0,16'h0103), e(1,1,16'h0203), e(2,0,16'h0303)};
    run("mm222", 6);
    chk("hold_after_run", {sel, ar_data}, {2'b10, 16'h0303});
    // stalled 1x1x1 with stray step in IDLE and in EMIT_B
    dim_m = 1; dim_n = 1; dim_p = 1;
    base_a = 16'h0010; base_b = 16'h0020; base_c = 16'h0030;
    step = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stray_idle", {busy, ar_write, done}, 0);
    end
    step = 0;
    start = 1;
    tick();
    start = 0;
    chk("stall_a", {ar_write, sel, last_k, ar_data}, {1'b1, 2'b00, 1'b0, 16'h0010});
    stall("stall_wait_a", 16'h0010, 2'b00);
    step = 1;
    tick();
    chk("stall_b", {ar_write, sel, last_k, ar_data}, {1'b1, 2'b01, 1'b1, 16'h0020});
    tick();
    step = 0;
    chk("stray_emit", {ar_write, last_k, busy}, {1'b0, 1'b0, 1'b1});
    stall("stall_wait_b", 16'h0020, 2'b01);
    step = 1;
    tick();
    step = 0;
    chk("stall_c", {ar_write, sel, last_k, ar_data}, {1'b1, 2'b10, 1'b0, 16'h0030});
    stall("stall_wait_c", 16'h0030, 2'b10);
    step = 1;
    tick();
    step = 0;
    chk("stall_done", {done, ar_write, busy}, {1'b1, 1'b0, 1'b1});
    tick();
    chk("stall_idle", {done, busy}, 0);
    // wrap-around at the top of the address space
    dim_m = 1; dim_n = 2; dim_p = 1;
    base_a = 16'hFFFF; base_b = 16'hFFFF; base_c = 16'h0040;
    exp_q = '{e(0,0,16'hFFFF), e(1,0,16'hFFFF), e(0,0,16'h0000), e(1,1,16'h0000), e(2,0,16'h0040)};
    run("wrap", -1);
    // zero dimension
    dim_m = 3; dim_n = 0; dim_p = 3;
    start = 1;
    tick();
    start = 0;
    chk("zero_fin", {done, busy, ar_write}, 3'b110);
    tick();
    chk("zero_idle", {done, busy, ar_write}, 0);
    // asynchronous reset mid-run
    dim_n = 2;
    base_a = 16'h0100; base_b = 16'h0200; base_c = 16'h0300;
    step = 1;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    #3 rst = 1;
    #1 chk_idle("async_reset");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle("reset_no_done");
    end
    rst = 0;
    step = 0;
    tick();
    chk_idle("reset_back_idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
